// File: rtl/nes_joypad_serializer.sv
// nes_joypad_serializer: NES controller responder that latches synchronized buttons and shifts one bit out per CPU read
module nes_joypad_serializer #(
  parameter int SYNC_STAGES = 2,
  parameter bit FILL_BIT = 1'b1,
  parameter bit MASK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       shift_pulse,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic [3:0] bits_read
);
  logic [7:0] sync [SYNC_STAGES];
  logic [7:0] btn_s, btn_m, sr;
  logic shift_pulse_q, shift_edge;
  assign btn_s = sync[SYNC_STAGES-1];
  assign btn_m = {(MASK_OPPOSING && (&btn_s[7:6])) ? 2'b00 : btn_s[7:6],
                  (MASK_OPPOSING && (&btn_s[5:4])) ? 2'b00 : btn_s[5:4],
                  btn_s[3:0]};
  assign shift_edge = shift_pulse & ~shift_pulse_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end
  // strobe outranks shift so a read during reload keeps returning A
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      bits_read <= '0;
      data_out <= 1'b0;
      shift_pulse_q <= 1'b0;
    end else begin
      shift_pulse_q <= shift_pulse;
      data_out <= sr[0];
      if (strobe) begin
        sr <= btn_m;
        bits_read <= '0;
      end else if (shift_edge) begin
        sr <= {FILL_BIT, sr[7:1]};
        bits_read <= bits_read + 4'(bits_read != 4'd8);
      end
    end
  end
endmodule

// File: tb/tb_nes_joypad_serializer.sv
// tb_nes_joypad_serializer: vector-table and corner-sequence checks over default, FILL_BIT=0 and MASK_OPPOSING=0 instances
module tb_nes_joypad_serializer;
  logic clk = 0, rst = 1, strobe = 1, shift_pulse = 0;
  logic [7:0] buttons = 8'hFF;
  logic [2:0] d;
  logic [3:0] br [3];
  int compared = 0, mismatched = 0;
  typedef struct {
    logic [7:0]  btn;
    logic [10:0] ed;
    logic [10:0] ef;
    logic [10:0] em;
  } vec_t;
  vec_t tv [5];
  always #5 clk = ~clk;
  nes_joypad_serializer u0 (.clk(clk), .rst(rst), .strobe(strobe), .shift_pulse(shift_pulse),
    .buttons(buttons), .data_out(d[0]), .bits_read(br[0]));
  nes_joypad_serializer #(.FILL_BIT(1'b0)) u1 (.clk(clk), .rst(rst), .strobe(strobe),
    .shift_pulse(shift_pulse), .buttons(buttons), .data_out(d[1]), .bits_read(br[1]));
  nes_joypad_serializer #(.MASK_OPPOSING(1'b0)) u2 (.clk(clk), .rst(rst), .strobe(strobe),
    .shift_pulse(shift_pulse), .buttons(buttons), .data_out(d[2]), .bits_read(br[2]));
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_all(input string nm, input logic [2:0] de, input logic [3:0] be);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s data_out u%0d", nm, k), {3'b0, d[k]}, {3'b0, de[k]});
      check($sformatf("%s bits_read u%0d", nm, k), br[k], be);
    end
  endtask
  task automatic latch(input logic [7:0] b);
    buttons = b;
    strobe = 1;
    tick(4);
    strobe = 0;
    tick(1);
  endtask
  task automatic pulse();
    shift_pulse = 1;
    tick(1);
    shift_pulse = 0;
    tick(2);
  endtask
  initial begin
    tv = '{
      '{8'hA5, 11'h7A5, 11'h0A5, 11'h7A5},
      '{8'h31, 11'h701, 11'h001, 11'h731},
      '{8'hF0, 11'h700, 11'h000, 11'h7F0},
      '{8'hC3, 11'h703, 11'h003, 11'h7C3},
      '{8'h5A, 11'h75A, 11'h05A, 11'h75A}
    };
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_all($sformatf("reset c%0d", i), 3'b000, 4'd0);
    end
    rst = 0;
    tick(3);
    check_all("reset release +3", 3'b000, 4'd0);
    tick(1);
    check_all("reset release +4", 3'b111, 4'd0);
    for (int v = 0; v < 5; v++) begin
      latch(tv[v].btn);
      for (int i = 0; i < 11; i++) begin
        check_all($sformatf("vec%0d read%0d", v, i), {tv[v].em[i], tv[v].ef[i], tv[v].ed[i]},
                  (i > 8) ? 4'd8 : 4'(i));
        if (i == 3) buttons = ~tv[v].btn;
        pulse();
      end
    end
    buttons = 8'h01;
    strobe = 1;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      pulse();
      check_all($sformatf("strobe hold pulse%0d", i), 3'b111, 4'd0);
    end
    shift_pulse = 1;
    tick(1);
    strobe = 0;
    tick(1);
    shift_pulse = 0;
    tick(2);
    check_all("pulse at strobe fall", 3'b111, 4'd0);
    latch(8'h02);
    check_all("held latched", 3'b000, 4'd0);
    shift_pulse = 1;
    tick(1);
    check_all("held +1", 3'b000, 4'd1);
    tick(1);
    check_all("held +2", 3'b111, 4'd1);
    tick(4);
    check_all("held +6", 3'b111, 4'd1);
    shift_pulse = 0;
    tick(3);
    check_all("held released", 3'b111, 4'd1);
    latch(8'hA5);
    pulse();
    pulse();
    check_all("midread before rst", 3'b111, 4'd2);
    rst = 1;
    shift_pulse = 1;
    tick(1);
    check_all("midread rst", 3'b000, 4'd0);
    rst = 0;
    tick(1);
    check_all("pulse across rst", 3'b000, 4'd1);
    shift_pulse = 0;
    tick(2);
    check_all("post rst no strobe", 3'b000, 4'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
